// File: rtl/ddr3_cpu_cmd_gen_if.sv
`timescale 1ns/1ps
// ddr3_cpu_cmd_gen_if: request handshake and DDR3 command bus between the
// CPU request logic (master) and the command generator (slave).
interface ddr3_cpu_cmd_gen_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_bank;
    logic [14:0] req_row;
    logic [9:0]  req_col;
    logic        done;
    logic        CS_N;
    logic        RAS_N;
    logic        CAS_N;
    logic        WE_N;
    logic [14:0] ADDR;
    logic [2:0]  BA;

    modport master (
        output req_valid, req_we, req_bank, req_row, req_col,
        input  req_ready, done, CS_N, RAS_N, CAS_N, WE_N, ADDR, BA
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_row, req_col,
        output req_ready, done, CS_N, RAS_N, CAS_N, WE_N, ADDR, BA
    );
endinterface

// File: rtl/ddr3_cpu_cmd_gen.sv
`timescale 1ns/1ps
// ddr3_cpu_cmd_gen: turns single CPU read/write requests into timed one-cycle
// DDR3 commands (init NOP wait + MRS, ACT, RD/WR, PRE, periodic REF).
// Optional feature macro: DDR3_OPEN_PAGE_EN selects the open-row policy;
// when undefined every access is closed-page with auto-precharge.
module ddr3_cpu_cmd_gen #(
    parameter int T_INIT = 8,
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_RFC  = 8,
    parameter int T_REFI = 64
) (
    input logic               cpu_clk,
    input logic               RESET_N,
    ddr3_cpu_cmd_gen_if.slave bus
);

    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam int CW  = 16;
    localparam int RFW = $clog2(T_REFI + 1);

`ifdef DDR3_OPEN_PAGE_EN
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic       A10     = 1'b0;
    localparam int         RW_TAIL = 1;
    localparam logic [CW-1:0] L_RP = CW'(T_RP);
`else
    localparam logic       A10     = 1'b1;
    localparam int         RW_TAIL = T_RP;
`endif

    localparam logic [CW-1:0]  L_INIT    = CW'(T_INIT - 1);
    localparam logic [CW-1:0]  L_RCD     = CW'(T_RCD);
    localparam logic [CW-1:0]  L_RFC     = CW'(T_RFC);
    localparam logic [CW-1:0]  L_TAIL    = CW'(RW_TAIL);
    localparam logic [CW-1:0]  L_TAIL_M1 = CW'(RW_TAIL - 1);
    localparam logic [RFW-1:0] L_REFI    = RFW'(T_REFI - 1);

    typedef enum logic [3:0] {
        INIT, MRS, IDLE, ACT, ACT_WAIT, RW, RW_WAIT, PRE, PRE_WAIT, REF, REF_WAIT
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [3:0]     cmd;
    logic [14:0]    addr;
    logic [2:0]     ba;
    logic           ready;
    logic           done_r;
    logic           lat_we;
    logic [2:0]     lat_bank;
    logic [9:0]     lat_col;
    logic           ref_en;
    logic [RFW-1:0] ref_cnt;
    logic           ref_pending;
    logic           ref_hit;
    logic           ref_due;
`ifdef DDR3_OPEN_PAGE_EN
    logic [14:0]    lat_row;
    logic           open_valid;
    logic [2:0]     open_bank;
    logic [14:0]    open_row;
    logic           pre_ref;
`endif

    assign ref_hit = ref_en && !ref_pending && (ref_cnt == L_REFI);
    assign ref_due = ref_pending || ref_hit;

    assign {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N} = cmd;
    assign bus.ADDR      = addr;
    assign bus.BA        = ba;
    assign bus.req_ready = ready;
    assign bus.done      = done_r;

    // Refresh interval counter: runs from MRS onwards, raises a sticky request, restarts on REF.
    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            ref_en      <= 1'b0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (state == MRS) ref_en <= 1'b1;
            if (state == REF) begin
                ref_cnt     <= '0;
                ref_pending <= 1'b0;
            end else if (ref_en && !ref_pending) begin
                ref_cnt <= ref_cnt + 1'b1;
                if (ref_hit) ref_pending <= 1'b1;
            end
        end
    end

    // Command sequencer: each edge picks the next state and registers the command for it.
    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= INIT;
            cnt      <= '0;
            cmd      <= CMD_NOP;
            addr     <= '0;
            ba       <= '0;
            ready    <= 1'b0;
            done_r   <= 1'b0;
            lat_we   <= 1'b0;
            lat_bank <= '0;
            lat_col  <= '0;
`ifdef DDR3_OPEN_PAGE_EN
            lat_row    <= '0;
            open_valid <= 1'b0;
            open_bank  <= '0;
            open_row   <= '0;
            pre_ref    <= 1'b0;
`endif
        end else begin
            cmd    <= CMD_NOP;
            addr   <= '0;
            ba     <= '0;
            ready  <= 1'b0;
            done_r <= 1'b0;
            case (state)
                INIT: begin
                    if (cnt == L_INIT) begin
                        state <= MRS;
                        cmd   <= CMD_MRS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MRS: begin
                    state <= IDLE;
                    ready <= !ref_due;
                end
                IDLE: begin
                    if (ref_pending) begin
`ifdef DDR3_OPEN_PAGE_EN
                        if (open_valid) begin
                            state      <= PRE;
                            cnt        <= CW'(1);
                            cmd        <= CMD_PRE;
                            ba         <= open_bank;
                            pre_ref    <= 1'b1;
                            open_valid <= 1'b0;
                        end else begin
                            state <= REF;
                            cnt   <= CW'(1);
                            cmd   <= CMD_REF;
                        end
`else
                        state <= REF;
                        cnt   <= CW'(1);
                        cmd   <= CMD_REF;
`endif
                    end else if (bus.req_valid && ready) begin
                        lat_we   <= bus.req_we;
                        lat_bank <= bus.req_bank;
                        lat_col  <= bus.req_col;
`ifdef DDR3_OPEN_PAGE_EN
                        lat_row  <= bus.req_row;
                        if (open_valid && bus.req_bank == open_bank && bus.req_row == open_row) begin
                            state <= RW;
                            cmd   <= bus.req_we ? CMD_WR : CMD_RD;
                            addr  <= {4'b0000, A10, bus.req_col};
                            ba    <= bus.req_bank;
                        end else if (open_valid) begin
                            state   <= PRE;
                            cnt     <= CW'(1);
                            cmd     <= CMD_PRE;
                            ba      <= open_bank;
                            pre_ref <= 1'b0;
                        end else begin
                            state      <= ACT;
                            cnt        <= CW'(1);
                            cmd        <= CMD_ACT;
                            addr       <= bus.req_row;
                            ba         <= bus.req_bank;
                            open_valid <= 1'b1;
                            open_bank  <= bus.req_bank;
                            open_row   <= bus.req_row;
                        end
`else
                        state <= ACT;
                        cnt   <= CW'(1);
                        cmd   <= CMD_ACT;
                        addr  <= bus.req_row;
                        ba    <= bus.req_bank;
`endif
                    end else begin
                        ready <= !ref_due;
                    end
                end
                ACT, ACT_WAIT: begin
                    if (cnt == L_RCD) begin
                        state <= RW;
                        cmd   <= lat_we ? CMD_WR : CMD_RD;
                        addr  <= {4'b0000, A10, lat_col};
                        ba    <= lat_bank;
                    end else begin
                        state <= ACT_WAIT;
                        cnt   <= cnt + 1'b1;
                    end
                end
                RW: begin
                    state  <= RW_WAIT;
                    cnt    <= CW'(1);
                    done_r <= (RW_TAIL == 1);
                end
                RW_WAIT: begin
                    if (cnt == L_TAIL) begin
                        state <= IDLE;
                        ready <= !ref_due;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        done_r <= (cnt == L_TAIL_M1);
                    end
                end
`ifdef DDR3_OPEN_PAGE_EN
                PRE, PRE_WAIT: begin
                    if (cnt == L_RP) begin
                        cnt <= CW'(1);
                        if (pre_ref) begin
                            state <= REF;
                            cmd   <= CMD_REF;
                        end else begin
                            state      <= ACT;
                            cmd        <= CMD_ACT;
                            addr       <= lat_row;
                            ba         <= lat_bank;
                            open_valid <= 1'b1;
                            open_bank  <= lat_bank;
                            open_row   <= lat_row;
                        end
                    end else begin
                        state <= PRE_WAIT;
                        cnt   <= cnt + 1'b1;
                    end
                end
`endif
                REF, REF_WAIT: begin
                    if (cnt == L_RFC) begin
                        state <= IDLE;
                        ready <= !ref_due;
                    end else begin
                        state <= REF_WAIT;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
